// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared floating-point adder constants and operand layout
package fpu_pkg;

  localparam int SIZE_MANTISSA = 23;
  localparam int SIZE_EXPONENT = 8;
  localparam int OPERAND_W     = 1 + SIZE_EXPONENT + SIZE_MANTISSA;

  localparam int FRAC_LSB = 0;
  localparam int EXP_LSB  = SIZE_MANTISSA;
  localparam int SIGN_POS = SIZE_MANTISSA + SIZE_EXPONENT;

  localparam logic [SIZE_EXPONENT-1:0] EXP_ONES  = '1;
  localparam logic [SIZE_EXPONENT-1:0] EXP_ZERO  = '0;
  localparam logic [SIZE_MANTISSA-1:0] QNAN_FRAC = {1'b1, {(SIZE_MANTISSA-1){1'b0}}};

  typedef struct packed {
    logic                     sign;
    logic [SIZE_EXPONENT-1:0] exponent;
    logic [SIZE_MANTISSA-1:0] fraction;
  } fp_operand_t;

endpackage

// File: rtl/fpu_add_align_if.sv
// rtl/fpu_add_align_if.sv - operand/result handshake bundle for the align/add stage
interface fpu_add_align_if
  import fpu_pkg::*;
#(
  parameter int Size_Mantissa = SIZE_MANTISSA,
  parameter int Size_Exponent = SIZE_EXPONENT
) ();

  logic                                 in_valid;
  logic                                 in_ready;
  logic [Size_Exponent+Size_Mantissa:0] in_a;
  logic [Size_Exponent+Size_Mantissa:0] in_b;
  logic                                 in_sub;
  logic                                 out_valid;
  logic                                 out_ready;
  logic                                 out_sign;
  logic [Size_Exponent-1:0]             out_exponent;
  logic [Size_Mantissa+1:0]             out_mantissa;
  logic                                 out_special;
  logic [2:0]                           out_grs;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sign, out_exponent, out_mantissa, out_special, out_grs
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sign, out_exponent, out_mantissa, out_special, out_grs
  );

endinterface

// File: rtl/fpu_align_shifter.sv
// rtl/fpu_align_shifter.sv - saturating right shift of the smaller mantissa
// FPU_ALIGN_STICKY_EN keeps guard/round/sticky extension bits; otherwise they are truncated.
module fpu_align_shifter
  import fpu_pkg::*;
#(
  parameter int Size_Mantissa = SIZE_MANTISSA,
  parameter int Size_Exponent = SIZE_EXPONENT
) (
  input  logic [Size_Mantissa:0]   mant_i,
  input  logic [Size_Exponent-1:0] diff_i,
  output logic [Size_Mantissa:0]   aligned_o,
  output logic [2:0]               grs_o
);

`ifdef FPU_ALIGN_STICKY_EN
  localparam int W = Size_Mantissa + 4;
  localparam logic [Size_Exponent-1:0] SHIFT_SAT = Size_Exponent'(W);

  logic [W-1:0] ext;
  logic [W-1:0] shifted;
  logic         lost;

  always_comb begin
    ext     = {mant_i, 3'b000};
    shifted = '0;
    lost    = 1'b0;
    if (diff_i >= SHIFT_SAT) begin
      lost = |ext;
    end else begin
      shifted = ext >> diff_i;
      lost    = |(ext & ~({W{1'b1}} << diff_i));
    end
  end

  assign aligned_o = shifted[W-1:3];
  assign grs_o     = {shifted[2], shifted[1], shifted[0] | lost};
`else
  localparam logic [Size_Exponent-1:0] SHIFT_SAT = Size_Exponent'(Size_Mantissa + 1);

  always_comb begin
    aligned_o = '0;
    if (diff_i < SHIFT_SAT) aligned_o = mant_i >> diff_i;
  end

  assign grs_o = 3'b000;
`endif

endmodule

// File: rtl/fpu_add_align.sv
// rtl/fpu_add_align.sv - two-stage exponent compare / mantissa align / add
// FPU_ALIGN_STICKY_EN (in fpu_align_shifter) enables the out_grs bits.
module fpu_add_align
  import fpu_pkg::*;
#(
  parameter int Size_Mantissa = SIZE_MANTISSA,
  parameter int Size_Exponent = SIZE_EXPONENT
) (
  input  logic             clk,
  input  logic             rst_n,
  fpu_add_align_if.slave   bus
);

  localparam int MW = Size_Mantissa + 1;
  localparam int SW = Size_Mantissa + 2;
  localparam logic [Size_Exponent-1:0] EXP_MAX = '1;
  localparam logic [SW-1:0] MANT_QNAN = {2'b01, 1'b1, {(Size_Mantissa-1){1'b0}}};
  localparam logic [SW-1:0] MANT_INF  = {2'b01, {Size_Mantissa{1'b0}}};

  logic                     sign_a, sign_b_raw, sign_b;
  logic [Size_Exponent-1:0] exp_a, exp_b;
  logic [Size_Mantissa-1:0] frac_a, frac_b;
  logic [MW-1:0]            mant_a, mant_b;
  logic                     a_ge_b, a_inf, b_inf, a_nan, b_nan;

  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_sign_l_q, s1_sign_l_d;
  logic [Size_Exponent-1:0] s1_exp_l_q, s1_exp_l_d;
  logic [MW-1:0]            s1_mant_l_q, s1_mant_l_d;
  logic [MW-1:0]            s1_mant_s_q, s1_mant_s_d;
  logic [Size_Exponent-1:0] s1_diff_q, s1_diff_d;
  logic                     s1_sub_q, s1_sub_d;
  logic                     s1_special_q, s1_special_d;
  logic                     s1_nan_q, s1_nan_d;
  logic                     s1_spec_sign_q, s1_spec_sign_d;

  logic                     s2_valid_q, s2_valid_d;
  logic                     s2_sign_q, s2_sign_d;
  logic [Size_Exponent-1:0] s2_exp_q, s2_exp_d;
  logic [SW-1:0]            s2_mant_q, s2_mant_d;
  logic                     s2_special_q, s2_special_d;
  logic [2:0]               s2_grs_q, s2_grs_d;

  logic                     s1_load, s2_load;
  logic [MW-1:0]            aligned_s;
  logic [2:0]               grs_s;
  logic [SW-1:0]            sum;

  assign {sign_a, exp_a, frac_a}     = bus.in_a;
  assign {sign_b_raw, exp_b, frac_b} = bus.in_b;
  assign sign_b = sign_b_raw ^ bus.in_sub;

  // Exponent zero flushes the operand (denormals included) to an exact zero.
  assign mant_a = (exp_a == '0) ? '0 : {1'b1, frac_a};
  assign mant_b = (exp_b == '0) ? '0 : {1'b1, frac_b};
  assign a_ge_b = {exp_a, mant_a[Size_Mantissa-1:0]} >= {exp_b, mant_b[Size_Mantissa-1:0]};

  assign a_inf = (exp_a == EXP_MAX) && (frac_a == '0);
  assign b_inf = (exp_b == EXP_MAX) && (frac_b == '0);
  assign a_nan = (exp_a == EXP_MAX) && (frac_a != '0);
  assign b_nan = (exp_b == EXP_MAX) && (frac_b != '0);

  assign s2_load      = s1_valid_q && (!s2_valid_q || bus.out_ready);
  assign bus.in_ready = !s1_valid_q || s2_load;
  assign s1_load      = bus.in_valid && bus.in_ready;

  always_comb begin
    s1_sign_l_d    = a_ge_b ? sign_a : sign_b;
    s1_exp_l_d     = a_ge_b ? exp_a  : exp_b;
    s1_mant_l_d    = a_ge_b ? mant_a : mant_b;
    s1_mant_s_d    = a_ge_b ? mant_b : mant_a;
    s1_diff_d      = a_ge_b ? (exp_a - exp_b) : (exp_b - exp_a);
    s1_sub_d       = sign_a ^ sign_b;
    s1_special_d   = (exp_a == EXP_MAX) || (exp_b == EXP_MAX);
    s1_nan_d       = a_nan || b_nan || (a_inf && b_inf && (sign_a != sign_b));
    s1_spec_sign_d = s1_nan_d ? 1'b0 : (a_inf ? sign_a : sign_b);
    s1_valid_d     = s1_valid_q;
    if (s1_load)      s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;
  end

  fpu_align_shifter #(
    .Size_Mantissa (Size_Mantissa),
    .Size_Exponent (Size_Exponent)
  ) u_shifter (
    .mant_i    (s1_mant_s_q),
    .diff_i    (s1_diff_q),
    .aligned_o (aligned_s),
    .grs_o     (grs_s)
  );

  // L >= S by construction, so the subtract never borrows out of the top bit.
  assign sum = s1_sub_q ? ({1'b0, s1_mant_l_q} - {1'b0, aligned_s})
                        : ({1'b0, s1_mant_l_q} + {1'b0, aligned_s});

  always_comb begin
    s2_sign_d    = s1_sign_l_q;
    s2_exp_d     = s1_exp_l_q;
    s2_mant_d    = sum;
    s2_special_d = s1_special_q;
    s2_grs_d     = grs_s;
    if (s1_special_q) begin
      s2_sign_d = s1_spec_sign_q;
      s2_exp_d  = EXP_MAX;
      s2_mant_d = s1_nan_q ? MANT_QNAN : MANT_INF;
      s2_grs_d  = 3'b000;
    end else if (s1_sub_q && (sum == '0)) begin
      s2_sign_d = 1'b0;
    end
    s2_valid_d = s2_valid_q;
    if (s2_load)            s2_valid_d = 1'b1;
    else if (bus.out_ready) s2_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q     <= 1'b0;
      s1_sign_l_q    <= 1'b0;
      s1_exp_l_q     <= '0;
      s1_mant_l_q    <= '0;
      s1_mant_s_q    <= '0;
      s1_diff_q      <= '0;
      s1_sub_q       <= 1'b0;
      s1_special_q   <= 1'b0;
      s1_nan_q       <= 1'b0;
      s1_spec_sign_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_sign_l_q    <= s1_sign_l_d;
        s1_exp_l_q     <= s1_exp_l_d;
        s1_mant_l_q    <= s1_mant_l_d;
        s1_mant_s_q    <= s1_mant_s_d;
        s1_diff_q      <= s1_diff_d;
        s1_sub_q       <= s1_sub_d;
        s1_special_q   <= s1_special_d;
        s1_nan_q       <= s1_nan_d;
        s1_spec_sign_q <= s1_spec_sign_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q   <= 1'b0;
      s2_sign_q    <= 1'b0;
      s2_exp_q     <= '0;
      s2_mant_q    <= '0;
      s2_special_q <= 1'b0;
      s2_grs_q     <= 3'b000;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        s2_sign_q    <= s2_sign_d;
        s2_exp_q     <= s2_exp_d;
        s2_mant_q    <= s2_mant_d;
        s2_special_q <= s2_special_d;
        s2_grs_q     <= s2_grs_d;
      end
    end
  end

  assign bus.out_valid    = s2_valid_q;
  assign bus.out_sign     = s2_sign_q;
  assign bus.out_exponent = s2_exp_q;
  assign bus.out_mantissa = s2_mant_q;
  assign bus.out_special  = s2_special_q;
  assign bus.out_grs      = s2_grs_q;

endmodule

// File: tb/tb_fpu_add_align.sv
// tb/tb_fpu_add_align.sv - directed vector bench for fpu_add_align
module tb_fpu_add_align;
  import fpu_pkg::*;

`ifdef FPU_ALIGN_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [24:0] mant;
    logic [7:0]  exp;
    logic        sign;
    logic        special;
    logic [2:0]  grs;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs[16];

  always #5 clk = ~clk;

  fpu_add_align_if bus ();

  fpu_add_align dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sub);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = sub;
    bus.in_valid = 1'b1;
  endtask

  task automatic run_vec(input int i);
    int  lat;
    bit  got;
    vec_t v;
    v = vecs[i];
    @(posedge clk); #1;
    drive(v.a, v.b, v.sub);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 6) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) got = 1'b1;
    end
    check($sformatf("vec%0d_latency", i), lat, 2);
    check($sformatf("vec%0d_mant", i), 32'(bus.out_mantissa), 32'(v.mant));
    check($sformatf("vec%0d_exp", i), 32'(bus.out_exponent), 32'(v.exp));
    check($sformatf("vec%0d_sign", i), 32'(bus.out_sign), 32'(v.sign));
    check($sformatf("vec%0d_special", i), 32'(bus.out_special), 32'(v.special));
    check($sformatf("vec%0d_grs", i), 32'(bus.out_grs), STICKY ? 32'(v.grs) : 32'd0);
  endtask

  logic [31:0] st_a[4], st_b[4];
  logic        st_sub[4];
  logic [24:0] st_mant[4];
  logic [7:0]  st_exp[4];

  initial begin
    logic [24:0] held;
    logic [24:0] res_m[4];
    logic [7:0]  res_e[4];
    int          acc, nres, seen;
    bit          took;

    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 25'h1000000, 8'd127, 1'b0, 1'b0, 3'b000};
    vecs[1]  = '{32'h3FC00000, 32'h3F800000, 1'b1, 25'h0400000, 8'd127, 1'b0, 1'b0, 3'b000};
    vecs[2]  = '{32'h3F800000, 32'h3FC00000, 1'b1, 25'h0400000, 8'd127, 1'b1, 1'b0, 3'b000};
    vecs[3]  = '{32'h3F800000, 32'h30800000, 1'b0, 25'h0800000, 8'd127, 1'b0, 1'b0, 3'b001};
    vecs[4]  = '{32'h7F800000, 32'h7F800000, 1'b1, 25'h0C00000, EXP_ONES, 1'b0, 1'b1, 3'b000};
    vecs[5]  = '{32'h7F800000, 32'h3F800000, 1'b0, 25'h0800000, EXP_ONES, 1'b0, 1'b1, 3'b000};
    vecs[6]  = '{32'hBF800000, 32'hBF800000, 1'b1, 25'h0000000, 8'd127, 1'b0, 1'b0, 3'b000};
    vecs[7]  = '{32'h3F800000, 32'h3F000003, 1'b0, 25'h0C00001, 8'd127, 1'b0, 1'b0, 3'b100};
    vecs[8]  = '{32'h3F800000, 32'h3B800001, 1'b0, 25'h0808000, 8'd127, 1'b0, 1'b0, 3'b001};
    vecs[9]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 25'h0C00000, EXP_ONES, 1'b0, 1'b1, 3'b000};
    vecs[10] = '{32'hFF800000, 32'h3F800000, 1'b0, 25'h0800000, EXP_ONES, 1'b1, 1'b1, 3'b000};
    vecs[11] = '{32'h40000000, 32'h3F800000, 1'b1, 25'h0400000, 8'd128, 1'b0, 1'b0, 3'b000};
    vecs[12] = '{32'h00000001, 32'h3F800000, 1'b0, 25'h0800000, 8'd127, 1'b0, 1'b0, 3'b000};
    vecs[13] = '{32'hBF800000, 32'h40000000, 1'b0, 25'h0400000, 8'd128, 1'b0, 1'b0, 3'b000};
    vecs[14] = '{32'h3F800000, 32'h3B800001, 1'b1, 25'h07F8000, 8'd127, 1'b0, 1'b0, 3'b001};
    vecs[15] = '{32'h3F800000, 32'h7F800000, 1'b1, 25'h0800000, EXP_ONES, 1'b1, 1'b1, 3'b000};

    st_a = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h3F800000};
    st_b = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F000003};
    st_sub = '{1'b0, 1'b1, 1'b1, 1'b0};
    st_mant = '{25'h1000000, 25'h0400000, 25'h0400000, 25'h0C00001};
    st_exp = '{8'd127, 8'd127, 8'd128, 8'd127};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", 32'(bus.out_valid), 0);
    check("reset_in_ready", 32'(bus.in_ready), 1);
    check("reset_mant", 32'(bus.out_mantissa), 0);
    check("reset_exp", 32'(bus.out_exponent), 0);

    for (int i = 0; i < 16; i++) run_vec(i);

    // Backpressure: out_ready low for four cycles while four pairs stream in.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    acc = 0;
    nres = 0;
    seen = 0;
    held = '0;
    drive(st_a[0], st_b[0], st_sub[0]);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        if (nres < 4) begin
          res_m[nres] = bus.out_mantissa;
          res_e[nres] = bus.out_exponent;
        end
        nres++;
      end
      if (cyc == 2) begin
        check("stall_in_ready", 32'(bus.in_ready), 0);
        check("stall_accepts", acc, 2);
        held = bus.out_mantissa;
      end
      if (cyc == 5) begin
        check("stall_hold_valid", 32'(bus.out_valid), 1);
        check("stall_hold_mant", 32'(bus.out_mantissa), 32'(held));
      end
      @(posedge clk); #1;
      if (took) begin
        acc++;
        if (acc < 4) drive(st_a[acc], st_b[acc], st_sub[acc]);
        else bus.in_valid = 1'b0;
      end
      if (cyc == 5) bus.out_ready = 1'b1;
    end
    check("stream_count", nres, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < nres) begin
        check($sformatf("stream%0d_mant", k), 32'(res_m[k]), 32'(st_mant[k]));
        check($sformatf("stream%0d_exp", k), 32'(res_e[k]), 32'(st_exp[k]));
      end
    end

    // Asynchronous reset with both stages occupied.
    bus.out_ready = 1'b0;
    drive(st_a[0], st_b[0], st_sub[0]);
    @(posedge clk); #1;
    drive(st_a[3], st_b[3], st_sub[3]);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("prefill_out_valid", 32'(bus.out_valid), 1);
    check("prefill_in_ready", 32'(bus.in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 0);
    check("async_rst_mant", 32'(bus.out_mantissa), 0);
    check("async_rst_exp", 32'(bus.out_exponent), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 1);
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("post_rst_no_stale", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
